// File: rtl/scroll_display_engine.sv
// Self-timed scroller for eight 7-segment digits: an 8-slot character buffer rotated
// by an enable-based prescaler, driving registered active-low segment patterns.
module scroll_display_engine #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Dir,
    input  logic       WrEn,
    input  logic [2:0] WrAddr,
    input  logic [2:0] WrChar,
    output logic       Step,
    output logic [2:0] Pos,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [6:0] HEX6,
    output logic [6:0] HEX7
);

    localparam int CW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic {
        HOLD   = 1'b0,
        SCROLL = 1'b1
    } state_t;

    function automatic logic [6:0] seg_of(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = 7'b0001001;
            3'd1:    seg = 7'b0000110;
            3'd2:    seg = 7'b1000111;
            3'd3:    seg = 7'b1000000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Power-on message "HELLO" followed by three blanks
    function automatic logic [2:0] default_char(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'd0;
            3'd1:    code = 3'd1;
            3'd2:    code = 3'd2;
            3'd3:    code = 3'd2;
            3'd4:    code = 3'd3;
            default: code = 3'd4;
        endcase
        return code;
    endfunction

    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [2:0]      pos_r;
    logic [2:0]      pos_nxt_s;
    logic            step_r;
    logic            step_nxt_s;
    logic [2:0]      msg_r     [8];
    logic [2:0]      msg_nxt_s [8];
    logic [6:0]      hex_r     [8];
    logic [6:0]      hex_nxt_s [8];

    // Next-state: prescaler/rotation per mode, buffer write, and HEX from next-state msg/Pos
    always_comb begin
        state_s    = Run ? SCROLL : HOLD;
        cnt_nxt_s  = cnt_r;
        pos_nxt_s  = pos_r;
        step_nxt_s = 1'b0;
        msg_nxt_s  = msg_r;
        hex_nxt_s  = hex_r;

        case (state_s)
            SCROLL: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s  = '0;
                    step_nxt_s = 1'b1;
                    if (Dir) begin
                        pos_nxt_s = pos_r - 3'd1;
                    end else begin
                        pos_nxt_s = pos_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                end
            end
            HOLD: begin
                cnt_nxt_s = cnt_r;
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase

        if (WrEn) begin
            msg_nxt_s[WrAddr] = WrChar;
        end else begin
            msg_nxt_s = msg_r;
        end

        for (int k = 0; k < 8; k++) begin
            hex_nxt_s[7-k] = seg_of(msg_nxt_s[pos_nxt_s + 3'(k)]);
        end
    end

    // State and output registers; reset restores the default message at offset 0
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r  <= '0;
            pos_r  <= 3'd0;
            step_r <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                msg_r[k]   <= default_char(3'(k));
                hex_r[7-k] <= seg_of(default_char(3'(k)));
            end
        end else begin
            cnt_r  <= cnt_nxt_s;
            pos_r  <= pos_nxt_s;
            step_r <= step_nxt_s;
            msg_r  <= msg_nxt_s;
            hex_r  <= hex_nxt_s;
        end
    end

    assign Step = step_r;
    assign Pos  = pos_r;
    assign HEX0 = hex_r[0];
    assign HEX1 = hex_r[1];
    assign HEX2 = hex_r[2];
    assign HEX3 = hex_r[3];
    assign HEX4 = hex_r[4];
    assign HEX5 = hex_r[5];
    assign HEX6 = hex_r[6];
    assign HEX7 = hex_r[7];

endmodule

// File: tb/tb_scroll_display_engine.sv
// Directed self-checking bench for scroll_display_engine with TICK_DIV=4.
module tb_scroll_display_engine;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic       Dir;
    logic       WrEn;
    logic [2:0] WrAddr;
    logic [2:0] WrChar;
    logic       Step;
    logic [2:0] Pos;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int step_seen;

    scroll_display_engine #(.TICK_DIV(4)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .Dir    (Dir),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrChar (WrChar),
        .Step   (Step),
        .Pos    (Pos),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .HEX4   (HEX4),
        .HEX5   (HEX5),
        .HEX6   (HEX6),
        .HEX7   (HEX7)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_tb(input logic [2:0] code);
        logic [6:0] s;
        case (code)
            3'd0:    s = 7'b0001001;
            3'd1:    s = 7'b0000110;
            3'd2:    s = 7'b1000111;
            3'd3:    s = 7'b1000000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // codes packed as {HEX7 code, ..., HEX0 code}
    function automatic logic [55:0] disp_exp(input logic [23:0] codes);
        logic [55:0] d;
        for (int k = 0; k < 8; k++) begin
            d[55-7*k -: 7] = seg_tb(codes[23-3*k -: 3]);
        end
        return d;
    endfunction

    function automatic logic [55:0] disp_act();
        return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    localparam logic [23:0] HELLO   = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    localparam logic [23:0] ELLO_H  = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
    localparam logic [23:0] ELLOO_H = {3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};

    initial begin
        Reset = 1'b1; Run = 1'b0; Dir = 1'b0; WrEn = 1'b0; WrAddr = 3'd0; WrChar = 3'd0;
        cyc();
        chk_val("rst_step", 64'(Step), 64'd0);
        chk_val("rst_pos", 64'(Pos), 64'd0);
        chk_val("rst_hex7", 64'(HEX7), 64'(7'b0001001));
        chk_val("rst_hex3", 64'(HEX3), 64'(7'b1000000));
        chk_val("rst_disp", 64'(disp_act()), 64'(disp_exp(HELLO)));

        // 1: paused for 20 cycles
        Reset = 1'b0;
        step_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (Step) step_seen++;
        end
        chk_val("pause_steps", 64'(step_seen), 64'd0);
        chk_val("pause_pos", 64'(Pos), 64'd0);
        chk_val("pause_disp", 64'(disp_act()), 64'(disp_exp(HELLO)));

        // 2 and 3: scroll left for 32 cycles
        Run = 1'b1;
        step_seen = 0;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            if (Step) step_seen++;
            if (i <= 12) chk_val($sformatf("left_step_c%0d", i), 64'(Step), 64'((i % 4) == 0));
            if (i == 4) begin
                chk_val("left_pos1", 64'(Pos), 64'd1);
                chk_val("left_disp1", 64'(disp_act()), 64'(disp_exp(ELLO_H)));
            end
            if (i == 8)  chk_val("left_pos2", 64'(Pos), 64'd2);
            if (i == 12) chk_val("left_pos3", 64'(Pos), 64'd3);
            if (i == 28) chk_val("left_pos7", 64'(Pos), 64'd7);
        end
        chk_val("wrap_steps", 64'(step_seen), 64'd8);
        chk_val("wrap_pos", 64'(Pos), 64'd0);
        chk_val("wrap_disp", 64'(disp_act()), 64'(disp_exp(HELLO)));

        // 4: scroll right from reset
        Run = 1'b0; Reset = 1'b1;
        cyc();
        Reset = 1'b0; Run = 1'b1; Dir = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk_val("right_step", 64'(Step), 64'd1);
        chk_val("right_pos", 64'(Pos), 64'd7);
        chk_val("right_hex7", 64'(HEX7), 64'(7'b1111111));
        chk_val("right_hex6", 64'(HEX6), 64'(7'b0001001));
        chk_val("right_hex2", 64'(HEX2), 64'(7'b1000000));

        // 5: pause mid-count keeps the partial count
        Run = 1'b0; Dir = 1'b0; Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        step_seen = 0;
        for (int i = 0; i < 14; i++) begin
            Run = (i < 2 || i >= 12) ? 1'b1 : 1'b0;
            cyc();
            if (Step) step_seen++;
        end
        chk_val("pause_mid_steps", 64'(step_seen), 64'd1);
        chk_val("pause_mid_last", 64'(Step), 64'd1);
        chk_val("pause_mid_pos", 64'(Pos), 64'd1);
        Run = 1'b0;
        cyc();
        chk_val("pause_step_clr", 64'(Step), 64'd0);

        // 6: write coincident with a step, then reset mid-count
        Reset = 1'b1;
        cyc();
        Reset = 1'b0; Run = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        WrEn = 1'b1; WrAddr = 3'd5; WrChar = 3'd3;
        cyc();
        WrEn = 1'b0;
        chk_val("wr_step_pos", 64'(Pos), 64'd1);
        chk_val("wr_step_hex3", 64'(HEX3), 64'(7'b1000000));
        chk_val("wr_step_disp", 64'(disp_act()), 64'(disp_exp(ELLOO_H)));
        cyc();
        cyc();
        Reset = 1'b1;
        cyc();
        chk_val("rst_mid_pos", 64'(Pos), 64'd0);
        chk_val("rst_mid_step", 64'(Step), 64'd0);
        chk_val("rst_mid_disp", 64'(disp_act()), 64'(disp_exp(HELLO)));
        Reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk_val($sformatf("post_rst_step_c%0d", i), 64'(Step), 64'(i == 4));
        end
        chk_val("post_rst_pos", 64'(Pos), 64'd1);

        // write while paused to a slot then shown on HEX1 (Pos=1 shows msg[7] on HEX1)
        Run = 1'b0; WrEn = 1'b1; WrAddr = 3'd7; WrChar = 3'd1;
        cyc();
        WrEn = 1'b0;
        chk_val("pause_wr_hex1", 64'(HEX1), 64'(7'b0000110));
        chk_val("pause_wr_pos", 64'(Pos), 64'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
